// File: rtl/placer_bridge_pkg.sv
// Shared types and constants for the host-to-placer bridge.
package placer_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_ADDR,
    LOAD_STREAM,
    ACK_WAIT,
    RUN_WAIT,
    UNLOAD,
    STATUS
  } state_e;

  // err bit positions
  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_TIMEOUT  = 1;

  // status word flag positions, counted down from the MSB
  localparam int ST_TIMEOUT_FROM_MSB  = 0;
  localparam int ST_OVERFLOW_FROM_MSB = 1;

  function automatic int step_bytes(input int bus_width);
    return bus_width / 8;
  endfunction

endpackage

// File: rtl/placer_watchdog.sv
// Run watchdog: loadable down-counter; expired fires on the LIMIT-th enabled cycle after clear.
module placer_watchdog #(
  parameter int LIMIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  generate
    if (LIMIT == 0) begin : g_off
      logic unused_wd;
      assign unused_wd = ^{clk, rst, clear, en};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
      logic [CW-1:0] count;

      // holds LIMIT-1 after clear, so zero is seen on the LIMIT-th enabled cycle
      always_ff @(posedge clk) begin
        if (rst)                    count <= CW'(LIMIT - 1);
        else if (clear)             count <= CW'(LIMIT - 1);
        else if (en && count != '0) count <= count - 1'b1;
      end

      assign expired = en && (count == '0);
    end
  endgenerate

endmodule

// File: rtl/placer_host_bridge.sv
// Host mailbox <-> placer bridge: packet load handshakes, run start, bounded unload and status word.
module placer_host_bridge
  import placer_bridge_pkg::*;
#(
  parameter int N                = 16,
  parameter int BUS_WIDTH        = 32,
  parameter int ADDR_WIDTH       = 13,
  parameter int NUM_PACKETS      = N + 2,
  parameter int PACKET_WORDS     = N + 8,
  parameter int LOAD_BASE        = 0,
  parameter int UNLOAD_BASE      = 'h800,
  parameter int UNLOAD_MAX_WORDS = N,
  parameter int STATUS_ADDR      = 'hFFC,
  parameter int TIMEOUT_CYCLES   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done,
  output logic                    ack,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic [BUS_WIDTH-1:0]    data_out,
  input  logic [BUS_WIDTH-1:0]    data_in,
  output logic [BUS_WIDTH/8-1:0]  we,
  output logic                    ram_en,
  output logic                    ram_rst,
  output logic                    pl_rst,
  output logic                    pl_load_en,
  output logic [BUS_WIDTH-1:0]    pl_load_data,
  input  logic [BUS_WIDTH-1:0]    pl_unload_data,
  input  logic                    pl_complete,
  output logic [1:0]              err
);

  localparam int WE_W = BUS_WIDTH / 8;
  localparam int SCW  = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
  localparam int PCW  = $clog2(NUM_PACKETS + 1);
  localparam int WCW  = (UNLOAD_MAX_WORDS > 0) ? $clog2(UNLOAD_MAX_WORDS + 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] A_STEP   = ADDR_WIDTH'(step_bytes(BUS_WIDTH));
  localparam logic [ADDR_WIDTH-1:0] A_LOAD   = ADDR_WIDTH'(LOAD_BASE);
  localparam logic [ADDR_WIDTH-1:0] A_UNLOAD = ADDR_WIDTH'(UNLOAD_BASE);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(STATUS_ADDR);

  state_e                 state, state_d;
  logic [SCW-1:0]         step_cnt, step_cnt_d;
  logic [PCW-1:0]         packet_cnt, packet_cnt_d;
  logic [WCW-1:0]         wcnt, wcnt_d;
  logic                   seen, seen_d;
  logic [1:0]             err_d;
  logic [ADDR_WIDTH-1:0]  address_d;
  logic [BUS_WIDTH-1:0]   data_out_d;
  logic [WE_W-1:0]        we_d;
  logic                   ack_d, pl_load_en_d;
  logic                   wd_clear, wd_en, wd_expired;
  logic                   last_word, unload_done;

  assign ram_en       = 1'b1;
  assign ram_rst      = 1'b0;
  assign pl_rst       = rst;
  assign pl_load_data = data_in;

  assign last_word   = step_cnt == SCW'(PACKET_WORDS - 1);
  assign wd_en       = (state == UNLOAD) && !seen;
  assign unload_done = !pl_complete && (seen || wd_expired);

  placer_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .en      (wd_en),
    .expired (wd_expired)
  );

  function automatic logic [BUS_WIDTH-1:0] status_word(input logic tmo, input logic ovf,
                                                       input logic [WCW-1:0] cnt);
    logic [BUS_WIDTH-1:0] s;
    s = '0;
    s[WCW-1:0] = cnt;
    s[BUS_WIDTH-1-ST_TIMEOUT_FROM_MSB]  = tmo;
    s[BUS_WIDTH-1-ST_OVERFLOW_FROM_MSB] = ovf;
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:        if (done) state_d = LOAD_ADDR;
      LOAD_ADDR:   state_d = LOAD_STREAM;
      LOAD_STREAM: if (last_word) state_d = ACK_WAIT;
      // packet_cnt is zeroed by STATUS, so a delivered result always lands back in IDLE
      ACK_WAIT:    if (!done) state_d = (packet_cnt < PCW'(NUM_PACKETS)) ? IDLE : RUN_WAIT;
      RUN_WAIT:    if (done) state_d = UNLOAD;
      UNLOAD:      if (unload_done) state_d = STATUS;
      STATUS:      state_d = ACK_WAIT;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    address_d    = address;
    data_out_d   = data_out;
    we_d         = '0;
    ack_d        = ack;
    pl_load_en_d = 1'b0;
    step_cnt_d   = step_cnt;
    packet_cnt_d = packet_cnt;
    wcnt_d       = wcnt;
    seen_d       = seen;
    err_d        = err;
    wd_clear     = 1'b0;
    unique case (state)
      IDLE: if (done) address_d = A_LOAD;
      LOAD_ADDR: begin
        pl_load_en_d = 1'b1;
        address_d    = address + A_STEP;
        step_cnt_d   = '0;
      end
      LOAD_STREAM: begin
        address_d  = address + A_STEP;
        step_cnt_d = step_cnt + 1'b1;
        if (last_word) begin
          ack_d        = 1'b1;
          packet_cnt_d = packet_cnt + 1'b1;
        end
      end
      ACK_WAIT: if (!done) ack_d = 1'b0;
      RUN_WAIT: if (done) begin
        pl_load_en_d = 1'b1;
        address_d    = A_UNLOAD;
        wcnt_d       = '0;
        seen_d       = 1'b0;
        err_d        = '0;
        wd_clear     = 1'b1;
      end
      UNLOAD: begin
        // the registered write completes on this edge; move to the next slot afterwards
        if (|we) address_d = address + A_STEP;
        if (pl_complete) begin
          seen_d = 1'b1;
          if (wcnt < WCW'(UNLOAD_MAX_WORDS)) begin
            data_out_d = pl_unload_data;
            we_d       = '1;
            wcnt_d     = wcnt + 1'b1;
          end else begin
            err_d[ERR_OVERFLOW] = 1'b1;
          end
        end else if (unload_done) begin
          if (!seen) err_d[ERR_TIMEOUT] = 1'b1;
          address_d  = A_STATUS;
          we_d       = '1;
          data_out_d = status_word(!seen, err[ERR_OVERFLOW], wcnt);
        end
      end
      STATUS: begin
        ack_d        = 1'b1;
        packet_cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      address    <= '0;
      data_out   <= '0;
      we         <= '0;
      ack        <= 1'b0;
      pl_load_en <= 1'b0;
      step_cnt   <= '0;
      packet_cnt <= '0;
      wcnt       <= '0;
      seen       <= 1'b0;
      err        <= '0;
    end else begin
      address    <= address_d;
      data_out   <= data_out_d;
      we         <= we_d;
      ack        <= ack_d;
      pl_load_en <= pl_load_en_d;
      step_cnt   <= step_cnt_d;
      packet_cnt <= packet_cnt_d;
      wcnt       <= wcnt_d;
      seen       <= seen_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_placer_host_bridge.sv
// Scoreboard bench: host driver predicts placer-side words and BRAM writes by cycle; negedge monitors compare.
module tb_placer_host_bridge;

  localparam int N    = 4;
  localparam int BW   = 32;
  localparam int AW   = 13;
  localparam int NP   = N + 2;
  localparam int PW   = N + 8;
  localparam int MAXW = N;
  localparam int TMO  = 50;
  localparam int STEP = BW / 8;
  localparam int LB   = 0;
  localparam int UB   = 'h800;
  localparam int SA   = 'hFFC;
  localparam int MEMW = (1 << AW) / STEP;

  logic           clk = 1'b0;
  logic           rst, done, ack, ram_en, ram_rst, pl_rst, pl_load_en, pl_complete;
  logic [AW-1:0]  address;
  logic [BW-1:0]  data_out, data_in, pl_load_data, pl_unload_data;
  logic [BW/8-1:0] we;
  logic [1:0]     err;

  placer_host_bridge #(
    .N(N), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .done(done), .ack(ack), .address(address),
    .data_out(data_out), .data_in(data_in), .we(we), .ram_en(ram_en),
    .ram_rst(ram_rst), .pl_rst(pl_rst), .pl_load_en(pl_load_en),
    .pl_load_data(pl_load_data), .pl_unload_data(pl_unload_data),
    .pl_complete(pl_complete), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mailbox side of the BRAM; unload writes are checked by the monitor, not stored
  logic [BW-1:0] mem [0:MEMW-1];
  always @(posedge clk) data_in <= mem[int'(address) / STEP];

  typedef struct { int cyc; logic [AW-1:0] addr; logic [BW-1:0] data; } wr_t;
  typedef struct { int cyc; bit en; bit chk; logic [BW-1:0] data; } ld_t;
  wr_t wr_q[$];
  ld_t ld_q[$];
  wr_t wr_e;
  ld_t ld_e;

  int checks = 0, errors = 0;
  logic [1:0] exp_err = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // BRAM write monitor
  always @(negedge clk) begin
    while (wr_q.size() != 0 && wr_q[0].cyc < cyc) begin
      wr_e = wr_q.pop_front();
      checks++; errors++;
      $display("FAIL bram_write_missing: none at cycle %0d, expected addr %0h data %0h", wr_e.cyc, wr_e.addr, wr_e.data);
    end
    if (wr_q.size() != 0 && wr_q[0].cyc == cyc) begin
      wr_e = wr_q.pop_front();
      check("bram_we", 64'(we), 64'({(BW/8){1'b1}}));
      check("bram_addr", 64'(address), 64'(wr_e.addr));
      check("bram_data", 64'(data_out), 64'(wr_e.data));
    end else if (we !== '0) begin
      checks++; errors++;
      $display("FAIL bram_write_unexpected: got addr %0h data %0h we %0h, required no write", address, data_out, we);
    end
  end

  // placer load-port monitor
  always @(negedge clk) begin
    while (ld_q.size() != 0 && ld_q[0].cyc < cyc) begin
      ld_e = ld_q.pop_front();
      checks++; errors++;
      $display("FAIL load_missing: nothing checked at cycle %0d, expected data %0h", ld_e.cyc, ld_e.data);
    end
    if (ld_q.size() != 0 && ld_q[0].cyc == cyc) begin
      ld_e = ld_q.pop_front();
      check("pl_load_en", 64'(pl_load_en), 64'(ld_e.en));
      if (ld_e.chk) check("pl_load_data", 64'(pl_load_data), 64'(ld_e.data));
    end else if (pl_load_en !== 1'b0) begin
      checks++; errors++;
      $display("FAIL pl_load_en_unexpected: got %0b, required 0", pl_load_en);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input logic lvl, input int lim, output int n);
    n = 0;
    while (ack !== lvl && n < lim) begin step(); n++; end
  endtask

  task automatic load_packet(input int k, input bit seq);
    logic [BW-1:0] w;
    ld_t e;
    int c0, n;
    c0 = cyc;
    for (int i = 0; i < PW; i++) begin
      w = seq ? BW'(k * PW + i) : BW'($urandom);
      mem[LB / STEP + i] = w;
      e.cyc = c0 + 2 + i; e.en = (i == 0); e.chk = 1'b1; e.data = w;
      ld_q.push_back(e);
    end
    done = 1'b1;
    wait_ack(1'b1, 40, n);
    check("load_ack_latency", 64'(n), 64'(PW + 2));
    done = 1'b0;
    step();
    check("load_ack_drop", 64'(ack), 64'(0));
  endtask

  task automatic load_all(input bit seq);
    for (int k = 0; k < NP; k++) load_packet(k, seq);
  endtask

  task automatic run(input int n, input int dly);
    logic [BW-1:0] w, s;
    wr_t we_x;
    ld_t e;
    int c, m, nw, st_cyc;
    bit tmo, ovf;
    check("err_sticky", 64'(err), 64'(exp_err));
    c = cyc;
    e.cyc = c + 1; e.en = 1'b1; e.chk = 1'b0; e.data = '0;
    ld_q.push_back(e);
    done = 1'b1;
    repeat (dly) step();
    check("err_cleared", 64'(err), 64'(0));
    for (int j = 0; j < n; j++) begin
      w = BW'($urandom);
      pl_complete = 1'b1;
      pl_unload_data = w;
      if (j < MAXW) begin
        we_x.cyc = cyc + 1; we_x.addr = AW'(UB + j * STEP); we_x.data = w;
        wr_q.push_back(we_x);
      end
      step();
    end
    pl_complete = 1'b0;
    pl_unload_data = BW'($urandom);
    tmo = (n == 0);
    ovf = (n > MAXW);
    nw  = (n > MAXW) ? MAXW : n;
    s = BW'(nw);
    s[BW-1] = tmo;
    s[BW-2] = ovf;
    st_cyc = tmo ? (c + 1 + TMO) : (cyc + 1);
    we_x.cyc = st_cyc; we_x.addr = AW'(SA); we_x.data = s;
    wr_q.push_back(we_x);
    wait_ack(1'b1, TMO + 20, m);
    check("run_ack_latency", 64'(m), tmo ? 64'(TMO + 2 - dly) : 64'(2));
    exp_err = {tmo, ovf};
    check("run_err", 64'(err), 64'(exp_err));
    done = 1'b0;
    step();
    check("run_ack_drop", 64'(ack), 64'(0));
  endtask

  task automatic reset_mid_load();
    logic [BW-1:0] w;
    ld_t e;
    int c0;
    c0 = cyc;
    for (int i = 0; i < PW; i++) begin
      w = BW'($urandom);
      mem[LB / STEP + i] = w;
      if (i < 5) begin
        e.cyc = c0 + 2 + i; e.en = (i == 0); e.chk = 1'b1; e.data = w;
        ld_q.push_back(e);
      end
    end
    done = 1'b1;
    repeat (6) step();
    rst = 1'b1;
    done = 1'b0;
    step();
    check("rst_mid_we", 64'(we), 64'(0));
    check("rst_mid_ack", 64'(ack), 64'(0));
    check("rst_mid_addr", 64'(address), 64'(0));
    check("rst_mid_pl_rst", 64'(pl_rst), 64'(1));
    exp_err = 2'b00;
    rst = 1'b0;
    step();
    check("pl_rst_release", 64'(pl_rst), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MEMW; i++) mem[i] = '0;
    rst = 1'b1; done = 1'b0; pl_complete = 1'b0; pl_unload_data = '0;
    repeat (3) step();
    check("reset_ack", 64'(ack), 64'(0));
    check("reset_addr", 64'(address), 64'(0));
    check("reset_data_out", 64'(data_out), 64'(0));
    check("reset_we", 64'(we), 64'(0));
    check("reset_load_en", 64'(pl_load_en), 64'(0));
    check("reset_err", 64'(err), 64'(0));
    check("ram_en", 64'(ram_en), 64'(1));
    check("ram_rst", 64'(ram_rst), 64'(0));
    check("reset_pl_rst", 64'(pl_rst), 64'(1));
    rst = 1'b0;
    step();

    load_all(1'b1);
    run(4, 2);
    load_all(1'b0);
    run(6, 1);
    load_all(1'b0);
    run(0, 1);
    for (int k = 0; k < 3; k++) load_packet(k, 1'b0);
    reset_mid_load();
    load_all(1'b0);
    run(1, 3);
    for (int r = 0; r < 3; r++) begin
      load_all(1'b0);
      run(int'($urandom_range(1, 7)), int'($urandom_range(1, 5)));
    end

    repeat (4) step();
    check("wr_q_drain", 64'(wr_q.size()), 64'(0));
    check("ld_q_drain", 64'(ld_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/placer_host_bridge.md
# placer_host_bridge

Parametrised host-to-placer bridge between a host-visible byte-addressed BRAM mailbox and the systolic page placer array. The host loads NUM_PACKETS packets through a four-phase done/ack handshake. A further handshake starts the run and streams the placer result back into a separate unload region. A status word then reports word count, overflow and watchdog timeout. It supersedes the fixed 32-bit, single-region, no-error-reporting interface.

## Interface
- N, 16: placer size.
- BUS_WIDTH, 32: BRAM and placer data width; multiple of 8.
- ADDR_WIDTH, 13: BRAM byte address width.
- NUM_PACKETS, N+2: load packets per run.
- PACKET_WORDS, N+8: words per load packet.
- LOAD_BASE, 0: byte address of the load buffer.
- UNLOAD_BASE, 'h800: byte address of the unload buffer.
- UNLOAD_MAX_WORDS, N: unload capacity in words.
- STATUS_ADDR, 'hFFC: byte address of the status word.
- TIMEOUT_CYCLES, 0: run watchdog limit; 0 disables it.
- clk  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- done  in  1  host request; level signal.
- ack  out  1  bridge acknowledge.
- address  out  ADDR_WIDTH  BRAM byte address.
- data_out  out  BUS_WIDTH  BRAM write data.
- data_in  in  BUS_WIDTH  BRAM read data; 1-cycle read latency.
- we  out  BUS_WIDTH/8  byte write enables.
- ram_en  out  1  constant 1.
- ram_rst  out  1  constant 0.
- pl_rst  out  1  placer reset; equals rst.
- pl_load_en  out  1  placer load/start pulse.
- pl_load_data  out  BUS_WIDTH  driven combinationally from data_in.
- pl_unload_data  in  BUS_WIDTH  placer result word.
- pl_complete  in  1  high while the placer presents result words.
- err  out  2  sticky {timeout, overflow}; cleared at the start of the next run.

## Operation
- STEP = BUS_WIDTH/8. Addresses wrap modulo 2^ADDR_WIDTH.
- IDLE: on done, set address=LOAD_BASE, go to LOAD_ADDR.
- LOAD_ADDR (1 cycle):
  - set pl_load_en=1 and address+=STEP;
  - clear step counter;
  - go to LOAD_STREAM.
- LOAD_STREAM (PACKET_WORDS cycles):
  - set pl_load_en=0; address+=STEP each cycle.
  - On the last word: set ack=1, packet_cnt++, go to ACK_WAIT.
- ACK_WAIT: on ~done, set ack=0.
  - If a result was just delivered, or packet_cnt<NUM_PACKETS, go to IDLE.
  - Otherwise go to RUN_WAIT.
- RUN_WAIT: on done:
  - pulse pl_load_en for 1 cycle (start);
  - set address=UNLOAD_BASE and clear wcnt, err and the watchdog;
  - go to UNLOAD.
- UNLOAD, while pl_complete is high, per cycle:
  - if wcnt<UNLOAD_MAX_WORDS: data_out=pl_unload_data, we=all ones, address+=STEP after each written word, wcnt++;
  - otherwise: we=0, set err[0] (overflow), discard the word.
- UNLOAD exit:
  - pl_complete falls after at least one word: go to STATUS.
  - Watchdog reaches TIMEOUT_CYCLES (nonzero) with no word seen: set err[1], go to STATUS.
- STATUS (1 cycle):
  - address=STATUS_ADDR, we=all ones;
  - data_out: MSB = err[1], MSB-1 = err[0], low bits = wcnt zero-extended;
  - then set we=0, ack=1, packet_cnt=0, go to ACK_WAIT.
- done changes outside IDLE, ACK_WAIT and RUN_WAIT are ignored.
- pl_complete outside UNLOAD is ignored.

## Timing
- Reset values: ack=0, address=0, data_out=0, we=0, pl_load_en=0, err=0, counters=0, state=IDLE. ram_en=1 and ram_rst=0 always.
- Reset mid-operation: on the next edge, drop we and ack and return to IDLE. No partial status write.
- Load packet: done is sampled at edge e0. pl_load_en is high between e1 and e2, alongside word 0 on pl_load_data. Words 0..P-1 occupy the P cycles after e1. ack rises at e(P+1).
- Unload: each result word is written on the edge after it is sampled; throughput is 1 word/cycle.
- STATUS write occurs 1 cycle after pl_complete falls. ack follows on the next edge.
- Host must hold done until ack, then drop done before the next request.

## Structure
- Package placer_bridge_pkg:
  - state enum (IDLE, LOAD_ADDR, LOAD_STREAM, ACK_WAIT, RUN_WAIT, UNLOAD, STATUS);
  - status bit-position constants;
  - STEP helper function.
- Sub-module placer_watchdog: loadable down-counter with enable, clear and an expired flag. Disabled when TIMEOUT_CYCLES=0.

## Test plan
- N=4 (6 packets × 12 words), BRAM holds 0..71: each packet gives 1 pl_load_en pulse followed by 12 consecutive words in order; ack rises 13 cycles after done; 6 handshakes, then RUN_WAIT.
- Run, placer emits 4 words A0..A3: writes at 'h800/'h804/'h808/'h80C, then STATUS_ADDR gets 'h0000_0004, err=0, ack=1.
- Run, placer emits 6 words: only 4 written; status = 'h4000_0004; err=01.
- TIMEOUT_CYCLES=50, pl_complete never rises: status = 'h8000_0000 at cycle 51; err=10.
- rst asserted mid-LOAD_STREAM (word 5): next cycle we=0, ack=0, state IDLE; full reload then succeeds.
- BUS_WIDTH=64, ADDR_WIDTH=10: address steps by 8 and wraps at 'h3F8→'h000; we='hFF.
